serial_loader: RTL and testbench
================================

Name: serial_loader

Overview:
- Receives a program image over the FTDI UART line (ftdi_rx) and writes it byte by byte onto the CPU-side memory bus (address, data, write strobe).
- Holds the CPU stalled while a load session is in progress.
- Sits directly upstream of the memory map / RAM, as an alternate bus master beside the CPU.
- Lets new code be loaded into RAM without rebuilding the BIOS ROM image.

Parameters:
- BIT_DIV, 868, clk cycles per UART bit (100 MHz / 115200).
- TIMEOUT, 2_000_000, idle clk cycles mid-packet before abort (20 ms).
- SYNC_BYTE, 8'hA5, packet start marker.

Ports:
- clk  in  1  100 MHz system clock.
- rst  in  1  synchronous, active-high reset.
- rx  in  1  asynchronous UART line from FTDI, idle high.
- mem_addr  out  16  write address.
- mem_data  out  8  write data.
- mem_we  out  1  one-cycle write strobe; mem_addr/mem_data valid in the same cycle.
- cpu_hold  out  1  high for the whole session; top-level muxes the bus to the loader and stalls the CPU.
- done  out  1  one-cycle pulse on a good checksum.
- err  out  1  sticky error flag; cleared by the next SYNC_BYTE.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, receiver idle. rst mid-session aborts with no further writes; cpu_hold is 0 the cycle after rst.
- Receiver:
  - rx passes through a 2-FF synchronizer.
  - A falling edge starts a frame. Start bit is re-checked at BIT_DIV/2; if high, it is a glitch and the receiver returns to idle.
  - 8 data bits, LSB first, each sampled BIT_DIV cycles after the previous sample.
  - Stop bit sampled likewise. If stop = 0 (framing error), the byte is discarded, err is set, and the FSM returns to IDLE.
  - Valid byte: byte_valid pulses 1 cycle at the stop-bit sample.
- Packet format: SYNC, ADDR_H, ADDR_L, LEN, LEN data bytes, CSUM.
  - LEN = 0 means 256 bytes.
  - CSUM = 8-bit modular sum of the data bytes only.
- FSM states: IDLE -> ADDR_H -> ADDR_L -> LEN -> DATA -> CSUM -> IDLE. Each transition happens on byte_valid.
  - IDLE: non-SYNC bytes are ignored. On SYNC, cpu_hold <= 1, err <= 0, sum <= 0.
  - LEN: loads an 9-bit counter (0 is loaded as 256).
  - DATA, per byte: next cycle mem_we = 1 with mem_addr = ptr and mem_data = byte; ptr <= ptr+1 (wraps FFFF->0000); sum <= sum+byte; counter decrements. When the counter reaches 0, go to CSUM.
  - CSUM: on match, done pulses 1 cycle. On mismatch, err is set. Either way, cpu_hold <= 0 in the same cycle and the FSM returns to IDLE. Data already written is not rolled back.
- Timeout:
  - The counter resets on every byte_valid and runs only when the FSM is not IDLE.
  - Reaching TIMEOUT sets err, drops cpu_hold, and returns to IDLE.
- Latency: mem_we is asserted exactly 1 clk after byte_valid of each data byte.
- Bus-free guarantee: minimum spacing between strobes is 10*BIT_DIV clks. No handshake from memory is required; the memory must accept a write every cycle.
- mem_addr and mem_data hold their last values between strobes.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE, ADDR_H, ADDR_L, LEN, DATA, CSUM).
  - SYNC_BYTE default.
  - BIT_DIV default derived from a 100 MHz clock constant.
- One sub-module, uart_rx_core (synchronizer, bit timing, framing check), outputs: byte[7:0], byte_valid, frame_err. serial_loader holds the FSM, address pointer, checksum and timeout.

Test Plan:
- Packet A5 E0 00 03 11 22 33 66 -> writes E000=11, E001=22, E002=33; done pulses once; err=0; cpu_hold high from SYNC stop-bit until the CSUM byte.
- Same packet with CSUM 67 -> all 3 writes occur; err=1; done never pulses; cpu_hold=0 after CSUM.
- A5 FF FF 02 AA BB 65 -> writes FFFF=AA, then 0000=BB (address wrap); done=1.
- LEN=00 with 256 data bytes of 01 and CSUM 00 -> 256 mem_we pulses covering 1200..12FF; done=1.
- Garbage 00 13 before SYNC, plus a 0.3-bit low glitch on rx -> no state change, no writes, cpu_hold=0.
- Stop after ADDR_L for 2_000_000 clks -> err=1, cpu_hold=0. Separately, assert rst during DATA -> no further mem_we, all outputs 0 next cycle.

Source files
------------

// File: rtl/serial_loader_pkg.sv
// serial_loader_pkg
// Shared definitions for the serial program loader:
//   - FSM state encodings for the packet parser and the UART receiver
//   - default bit divider derived from the system clock and baud rate
//   - default packet sync marker and mid-packet timeout
package serial_loader_pkg;

  localparam int CLK_HZ          = 100_000_000;
  localparam int BAUD            = 115_200;
  localparam int BIT_DIV_DEFAULT = CLK_HZ / BAUD;
  localparam int TIMEOUT_DEFAULT = 2_000_000;
  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR_H,
    ST_ADDR_L,
    ST_LEN,
    ST_DATA,
    ST_CSUM
  } loader_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/serial_loader_if.sv
// serial_loader_if
// Memory-side bus driven by the loader while it owns RAM.
//   mem_addr  16-bit write address
//   mem_data  8-bit write data
//   mem_we    one-cycle write strobe, address/data valid in the same cycle
//   cpu_hold  high while the loader owns the bus and the CPU is stalled
// master: the loader; slave: the memory map / bus mux.
interface serial_loader_if;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data;
  logic        mem_we;
  logic        cpu_hold;

  modport master (output mem_addr, mem_data, mem_we, cpu_hold);
  modport slave  (input  mem_addr, mem_data, mem_we, cpu_hold);
endinterface

// File: rtl/serial_loader_uart_rx_core.sv
// uart_rx_core
// 8N1 UART receiver with a 2-FF input synchronizer.
//   clk, rst     system clock, synchronous active-high reset
//   rx           asynchronous serial line, idle high
//   rx_byte      last received byte (valid while byte_valid is high)
//   byte_valid   one-cycle pulse at the stop-bit sample of a good frame
//   frame_err    one-cycle pulse when the stop bit is sampled low
module uart_rx_core
  import serial_loader_pkg::*;
#(
  parameter int BIT_DIV = BIT_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err
);

  rx_state_t   state_q, state_d;
  logic        rx_meta, rx_s, rx_prev;
  logic [15:0] cnt_q;
  logic [2:0]  bit_idx_q;
  logic [7:0]  shreg_q;
  logic        bit_tick, half_tick;

  assign bit_tick  = (cnt_q == 16'(BIT_DIV - 1));
  assign half_tick = (cnt_q == 16'(BIT_DIV / 2 - 1));
  assign rx_byte   = shreg_q;

  // Next-state logic. The start bit is re-checked half a bit after the
  // falling edge so short glitches do not start a frame; every following
  // sample lands a full bit later, i.e. mid-bit.
  always_comb begin
    state_d    = state_q;
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    case (state_q)
      RX_IDLE:  if (rx_prev && !rx_s) state_d = RX_START;
      RX_START: if (half_tick) state_d = rx_s ? RX_IDLE : RX_DATA;
      RX_DATA:  if (bit_tick && bit_idx_q == 3'd7) state_d = RX_STOP;
      RX_STOP: begin
        if (bit_tick) begin
          state_d    = RX_IDLE;
          byte_valid = rx_s;
          frame_err  = !rx_s;
        end
      end
      default:  state_d = RX_IDLE;
    endcase
  end

  // Synchronizer, bit timer and shift register. The timer restarts on every
  // state change and after each full-bit sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta   <= 1'b1;
      rx_s      <= 1'b1;
      rx_prev   <= 1'b1;
      state_q   <= RX_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
      state_q <= state_d;
      if (state_q == RX_IDLE || state_d != state_q || bit_tick)
        cnt_q <= '0;
      else
        cnt_q <= cnt_q + 16'd1;
      if (state_q == RX_IDLE)
        bit_idx_q <= '0;
      else if (state_q == RX_DATA && bit_tick) begin
        shreg_q   <= {rx_s, shreg_q[7:1]};
        bit_idx_q <= bit_idx_q + 3'd1;
      end
    end
  end

endmodule

// File: rtl/serial_loader.sv
// serial_loader
// Loads a program image received over the FTDI UART into RAM.
// Packet: SYNC, ADDR_H, ADDR_L, LEN (0 = 256), LEN data bytes, CSUM
// (8-bit sum of the data bytes).
//   clk, rst   system clock, synchronous active-high reset
//   rx         UART line from the FTDI chip, idle high
//   bus        master side of serial_loader_if (mem_addr, mem_data,
//              mem_we, cpu_hold)
//   done       one-cycle pulse when a packet checksum matches
//   err        sticky error (bad checksum, framing error, timeout),
//              cleared by the next SYNC byte
module serial_loader
  import serial_loader_pkg::*;
#(
  parameter int         BIT_DIV   = BIT_DIV_DEFAULT,
  parameter int         TIMEOUT   = TIMEOUT_DEFAULT,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx,
  serial_loader_if.master  bus,
  output logic             done,
  output logic             err
);

  loader_state_t state_q, state_d;
  logic [7:0]    rx_byte;
  logic          byte_valid, frame_err;
  logic [15:0]   ptr_q;
  logic [8:0]    cnt_q;
  logic [7:0]    sum_q;
  logic [31:0]   tmo_q;
  logic          tmo_hit, abort;

  uart_rx_core #(.BIT_DIV(BIT_DIV)) u_rx (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .rx_byte    (rx_byte),
    .byte_valid (byte_valid),
    .frame_err  (frame_err)
  );

  // The timeout counter is held at zero in IDLE, so it can only fire mid-packet.
  assign tmo_hit = (tmo_q == 32'(TIMEOUT - 1));
  assign abort   = frame_err || tmo_hit;

  // Packet parser next state. Aborts take priority over byte arrivals.
  always_comb begin
    state_d = state_q;
    if (abort)
      state_d = ST_IDLE;
    else if (byte_valid) begin
      case (state_q)
        ST_IDLE:   if (rx_byte == SYNC_BYTE) state_d = ST_ADDR_H;
        ST_ADDR_H: state_d = ST_ADDR_L;
        ST_ADDR_L: state_d = ST_LEN;
        ST_LEN:    state_d = ST_DATA;
        ST_DATA:   if (cnt_q == 9'd1) state_d = ST_CSUM;
        ST_CSUM:   state_d = ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // Datapath: address pointer, byte counter, running checksum, bus outputs.
  // mem_we is registered so it lands exactly one cycle after byte_valid;
  // mem_addr/mem_data keep their last values between strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      cnt_q        <= '0;
      sum_q        <= '0;
      tmo_q        <= '0;
      bus.mem_addr <= '0;
      bus.mem_data <= '0;
      bus.mem_we   <= 1'b0;
      bus.cpu_hold <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      state_q    <= state_d;
      bus.mem_we <= 1'b0;
      done       <= 1'b0;
      if (byte_valid || state_q == ST_IDLE)
        tmo_q <= '0;
      else
        tmo_q <= tmo_q + 32'd1;
      if (abort) begin
        err          <= 1'b1;
        bus.cpu_hold <= 1'b0;
      end else if (byte_valid) begin
        case (state_q)
          ST_IDLE: begin
            if (rx_byte == SYNC_BYTE) begin
              bus.cpu_hold <= 1'b1;
              err          <= 1'b0;
              sum_q        <= '0;
            end
          end
          ST_ADDR_H: ptr_q[15:8] <= rx_byte;
          ST_ADDR_L: ptr_q[7:0]  <= rx_byte;
          ST_LEN:    cnt_q       <= {(rx_byte == 8'h00), rx_byte};
          ST_DATA: begin
            bus.mem_we   <= 1'b1;
            bus.mem_addr <= ptr_q;
            bus.mem_data <= rx_byte;
            ptr_q        <= ptr_q + 16'd1;
            sum_q        <= sum_q + rx_byte;
            cnt_q        <= cnt_q - 9'd1;
          end
          ST_CSUM: begin
            if (rx_byte == sum_q) done <= 1'b1;
            else                  err  <= 1'b1;
            bus.cpu_hold <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_serial_loader.sv
// tb_serial_loader
// Directed bench for serial_loader: drives UART frames on rx, records every
// memory write strobe and done pulse, and compares against hand-computed
// expectations. Uses a short bit divider and timeout to keep runs small.
module tb_serial_loader;

  localparam int BIT_DIV = 8;
  localparam int TIMEOUT = 1000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;
  logic done, err;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;
  logic [15:0] wr_addr[$];
  logic [7:0]  wr_data[$];

  serial_loader_if bus_if ();

  serial_loader #(.BIT_DIV(BIT_DIV), .TIMEOUT(TIMEOUT)) dut (
    .clk  (clk),
    .rst  (rst),
    .rx   (rx),
    .bus  (bus_if),
    .done (done),
    .err  (err)
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  // Record bus writes and done pulses on the falling edge, away from the
  // active edge.
  always @(negedge clk) begin
    if (bus_if.mem_we) begin
      wr_addr.push_back(bus_if.mem_addr);
      wr_data.push_back(bus_if.mem_data);
    end
    if (done) done_cnt++;
  end

  // Hard stop in case something wedges the run.
  initial begin
    #5ms;
    $display("[TB] FAIL watchdog actual=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  // One UART frame: start bit, 8 data bits LSB first, then the given stop bit.
  task automatic applyStimulus(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (BIT_DIV) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BIT_DIV) @(posedge clk);
    end
    rx = stop_bit;
    repeat (BIT_DIV) @(posedge clk);
    rx = 1'b1;
  endtask

  task automatic sendByte(input logic [7:0] b);
    applyStimulus(b, 1'b1);
  endtask

  task automatic settle();
    repeat (2 * BIT_DIV) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clearLog();
    wr_addr.delete();
    wr_data.delete();
    done_cnt = 0;
  endtask

  initial begin
    int bad;
    logic [7:0] exp_d;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_we",   32'(bus_if.mem_we),   0);
    checkOutput("rst_hold", 32'(bus_if.cpu_hold), 0);
    checkOutput("rst_addr", 32'(bus_if.mem_addr), 0);
    checkOutput("rst_data", 32'(bus_if.mem_data), 0);
    checkOutput("rst_done", 32'(done),            0);
    checkOutput("rst_err",  32'(err),             0);
    rst = 1'b0;
    repeat (2 * BIT_DIV) @(posedge clk);

    // Good packet: E000=11, E001=22, E002=33, csum 66
    clearLog();
    sendByte(8'hA5);
    repeat (4) @(posedge clk);
    @(negedge clk);
    checkOutput("a_hold_after_sync", 32'(bus_if.cpu_hold), 1);
    sendByte(8'hE0); sendByte(8'h00); sendByte(8'h03);
    sendByte(8'h11); sendByte(8'h22); sendByte(8'h33);
    @(negedge clk);
    checkOutput("a_hold_before_csum", 32'(bus_if.cpu_hold), 1);
    sendByte(8'h66);
    settle();
    checkOutput("a_writes", wr_addr.size(), 3);
    if (wr_addr.size() == 3) begin
      checkOutput("a_addr0", 32'(wr_addr[0]), 32'hE000);
      checkOutput("a_data0", 32'(wr_data[0]), 32'h11);
      checkOutput("a_addr1", 32'(wr_addr[1]), 32'hE001);
      checkOutput("a_data1", 32'(wr_data[1]), 32'h22);
      checkOutput("a_addr2", 32'(wr_addr[2]), 32'hE002);
      checkOutput("a_data2", 32'(wr_data[2]), 32'h33);
    end
    checkOutput("a_done", done_cnt, 1);
    checkOutput("a_err",  32'(err), 0);
    checkOutput("a_hold_end", 32'(bus_if.cpu_hold), 0);
    checkOutput("a_addr_hold", 32'(bus_if.mem_addr), 32'hE002);

    // Same packet, wrong checksum
    clearLog();
    sendByte(8'hA5); sendByte(8'hE0); sendByte(8'h00); sendByte(8'h03);
    sendByte(8'h11); sendByte(8'h22); sendByte(8'h33); sendByte(8'h67);
    settle();
    checkOutput("b_writes", wr_addr.size(), 3);
    checkOutput("b_err",  32'(err), 1);
    checkOutput("b_done", done_cnt, 0);
    checkOutput("b_hold", 32'(bus_if.cpu_hold), 0);

    // Address wrap FFFF -> 0000
    clearLog();
    sendByte(8'hA5); sendByte(8'hFF); sendByte(8'hFF); sendByte(8'h02);
    sendByte(8'hAA); sendByte(8'hBB); sendByte(8'h65);
    settle();
    checkOutput("c_writes", wr_addr.size(), 2);
    if (wr_addr.size() == 2) begin
      checkOutput("c_addr0", 32'(wr_addr[0]), 32'hFFFF);
      checkOutput("c_data0", 32'(wr_data[0]), 32'hAA);
      checkOutput("c_addr1", 32'(wr_addr[1]), 32'h0000);
      checkOutput("c_data1", 32'(wr_data[1]), 32'hBB);
    end
    checkOutput("c_done", done_cnt, 1);
    checkOutput("c_err",  32'(err), 0);

    // Framing error mid-session
    clearLog();
    sendByte(8'hA5);
    applyStimulus(8'h12, 1'b0);
    settle();
    checkOutput("f_err",  32'(err), 1);
    checkOutput("f_hold", 32'(bus_if.cpu_hold), 0);

    // LEN=0 -> 256 bytes of 01 at 1200..12FF, csum 00
    clearLog();
    sendByte(8'hA5); sendByte(8'h12); sendByte(8'h00); sendByte(8'h00);
    for (int i = 0; i < 256; i++) sendByte(8'h01);
    sendByte(8'h00);
    settle();
    checkOutput("d_writes", wr_addr.size(), 256);
    bad = 0;
    for (int i = 0; i < wr_addr.size(); i++)
      if (wr_addr[i] !== 16'h1200 + 16'(i) || wr_data[i] !== 8'h01) bad++;
    checkOutput("d_bad_writes", bad, 0);
    checkOutput("d_done", done_cnt, 1);
    checkOutput("d_err",  32'(err), 0);

    // Garbage and a short low glitch must not start a session
    clearLog();
    sendByte(8'h00); sendByte(8'h13);
    rx = 1'b0;
    repeat (2) @(posedge clk);
    rx = 1'b1;
    settle();
    checkOutput("g_writes", wr_addr.size(), 0);
    checkOutput("g_hold",   32'(bus_if.cpu_hold), 0);
    checkOutput("g_err",    32'(err), 0);
    sendByte(8'hA5); sendByte(8'h20); sendByte(8'h00); sendByte(8'h01);
    sendByte(8'h5A); sendByte(8'h5A);
    settle();
    checkOutput("g_post_writes", wr_addr.size(), 1);
    if (wr_addr.size() == 1) begin
      checkOutput("g_post_addr", 32'(wr_addr[0]), 32'h2000);
      checkOutput("g_post_data", 32'(wr_data[0]), 32'h5A);
    end
    checkOutput("g_post_done", done_cnt, 1);

    // Stall after ADDR_L -> timeout
    clearLog();
    sendByte(8'hA5); sendByte(8'h30); sendByte(8'h00);
    repeat (TIMEOUT / 2) @(posedge clk);
    @(negedge clk);
    checkOutput("t_hold_mid", 32'(bus_if.cpu_hold), 1);
    checkOutput("t_err_mid",  32'(err), 0);
    repeat (TIMEOUT) @(posedge clk);
    @(negedge clk);
    checkOutput("t_err",  32'(err), 1);
    checkOutput("t_hold", 32'(bus_if.cpu_hold), 0);

    // Reset during DATA: no further writes, outputs cleared next cycle
    clearLog();
    sendByte(8'hA5); sendByte(8'h40); sendByte(8'h00); sendByte(8'h04);
    sendByte(8'h01); sendByte(8'h02);
    repeat (4) @(posedge clk);
    @(negedge clk);
    checkOutput("r_hold_before", 32'(bus_if.cpu_hold), 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("r_hold", 32'(bus_if.cpu_hold), 0);
    checkOutput("r_addr", 32'(bus_if.mem_addr), 0);
    checkOutput("r_err",  32'(err), 0);
    rst = 1'b0;
    sendByte(8'h03); sendByte(8'h04); sendByte(8'h0A);
    settle();
    checkOutput("r_writes", wr_addr.size(), 2);
    exp_d = 8'h02;
    if (wr_addr.size() == 2) checkOutput("r_last_data", 32'(wr_data[1]), 32'(exp_d));
    checkOutput("r_done", done_cnt, 0);
    checkOutput("r_hold_after", 32'(bus_if.cpu_hold), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
